muldiv_unit: RTL and testbench



---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative multiply/divide unit: op codes, FSM states
// and the default operand width.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage side of the multiply/divide unit: operation request, MTHI/MTLO
// writes and the HI/LO results. master = pipeline control, slave = muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);

    // start is only taken while busy=0; there is no back-pressure beyond busy,
    // and done is a one-cycle pulse marking the cycle HI/LO were updated.
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, data1, data2, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, data1, data2, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring
// trial-subtract divide, selected by is_div. Purely combinational.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH:0]     rem,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH:0]     rem_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        // Multiply: acc = {partial product, remaining multiplier bits}.
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: acc[WIDTH-1:0] shifts dividend bits out and quotient bits in.
        shifted = {rem, acc[WIDTH-1]};
        diff    = shifted - {2'b00, operand};
        fits    = ~diff[WIDTH+1];

        if (is_div) begin
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], fits};
            rem_next = fits ? diff[WIDTH:0] : shifted[WIDTH:0];
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
            rem_next = rem;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers. Works on operand
// magnitudes for WIDTH cycles, then applies signs in a single FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus,
    output state_t   dbg_state
);

    localparam int CW = $clog2(WIDTH);

    state_t state, state_next;
    logic   busy, load, step_en, fix_en;

    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic               sign1_q, sign2_q, zero_q;
    logic [WIDTH-1:0]   data1_q, operand_q;
    logic [2*WIDTH-1:0] acc, acc_next;
    logic [WIDTH:0]     rem, rem_next;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q, dbz_q;

    logic               sign1, sign2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot, rmd, res_hi, res_lo;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_CALC;
            ST_CALC: if (count == CW'(WIDTH - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != ST_IDLE);
        load    = (state == ST_IDLE) && bus.start;
        step_en = (state == ST_CALC);
        fix_en  = (state == ST_FIX);
    end

    // Signed ops (MULT, DIV) have op[0]=0; unsigned ops keep raw operands.
    always_comb begin
        sign1 = ~bus.op[0] & bus.data1[WIDTH-1];
        sign2 = ~bus.op[0] & bus.data2[WIDTH-1];
        mag1  = sign1 ? -bus.data1 : bus.data1;
        mag2  = sign2 ? -bus.data2 : bus.data2;
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (op_q[1]),
        .acc      (acc),
        .rem      (rem),
        .operand  (operand_q),
        .acc_next (acc_next),
        .rem_next (rem_next)
    );

    // Sign fix-up; most-negative / -1 wraps naturally through the negation.
    always_comb begin
        product = (op_q == OP_MULT && (sign1_q ^ sign2_q)) ? -acc : acc;
        quot    = acc[WIDTH-1:0];
        rmd     = rem[WIDTH-1:0];
        if (op_q == OP_DIV) begin
            if (sign1_q ^ sign2_q) quot = -quot;
            if (sign1_q)           rmd  = -rmd;
        end
        if (zero_q) begin
            quot = '1;
            rmd  = data1_q;
        end
        if (op_q[1]) {res_hi, res_lo} = {rmd, quot};
        else         {res_hi, res_lo} = product;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            op_q      <= OP_MULT;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            zero_q    <= 1'b0;
            data1_q   <= '0;
            operand_q <= '0;
            acc       <= '0;
            rem       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            done_q <= fix_en;
            if (!busy) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
            if (load) begin
                count     <= '0;
                op_q      <= bus.op;
                sign1_q   <= sign1;
                sign2_q   <= sign2;
                zero_q    <= (bus.data2 == '0);
                data1_q   <= bus.data1;
                operand_q <= mag2;
                acc       <= {{WIDTH{1'b0}}, mag1};
                rem       <= '0;
                dbz_q     <= 1'b0;
            end
            if (step_en) begin
                acc   <= acc_next;
                rem   <= rem_next;
                count <= count + CW'(1);
            end
            if (fix_en) begin
                hi_q  <= res_hi;
                lo_q  <= res_lo;
                dbz_q <= op_q[1] & zero_q;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a cycle-level arithmetic model checked every
// cycle, plus hand-computed HI/LO literals at the end of each operation.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;
    int     total = 0;
    int     bad   = 0;
    bit     cmp_en = 1'b0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {div_by_zero, hi, lo} from plain integer arithmetic.
    function automatic logic [64:0] model_result(input logic [1:0] op,
                                                 input logic [W-1:0] a,
                                                 input logic [W-1:0] b);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULT:  begin p = sa * sb; return {1'b0, p}; end
            OP_MULTU: begin p = 64'(a) * 64'(b); return {1'b0, p}; end
            default: begin
                if (b == '0) return {1'b1, a, {W{1'b1}}};
                if (op == OP_DIV) begin q = sa / sb; r = sa % sb; end
                else              begin q = 64'(a) / 64'(b); r = 64'(a) % 64'(b); end
                return {1'b0, r[W-1:0], q[W-1:0]};
            end
        endcase
    endfunction

    // Model: an accepted start counts down WIDTH+1 edges, then HI/LO update.
    int          m_left = 0;
    logic [64:0] m_pend = '0;
    logic [W-1:0] m_hi = '0, m_lo = '0;
    logic        m_dbz = 1'b0, m_done = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_hi = '0; m_lo = '0; m_dbz = 1'b0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    {m_dbz, m_hi, m_lo} = m_pend;
                    m_done = 1'b1;
                end
            end else begin
                if (bus.hi_we) m_hi = bus.wdata;
                if (bus.lo_we) m_lo = bus.wdata;
                if (bus.start) begin
                    m_pend = model_result(bus.op, bus.data1, bus.data2);
                    m_left = W + 1;
                    m_dbz  = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("cyc_busy", 64'(bus.busy), 64'(m_left != 0));
            chk("cyc_done", 64'(bus.done), 64'(m_done));
            chk("cyc_dbz",  64'(bus.div_by_zero), 64'(m_dbz));
            chk("cyc_hi",   64'(bus.hi), 64'(m_hi));
            chk("cyc_lo",   64'(bus.lo), 64'(m_lo));
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int already, output int cycles);
        cycles = already;
        while (!bus.done && cycles < 60) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({name, "_latency"}, 64'(cycles), 64'(W + 1));
    endtask

    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo,
                          input logic edbz);
        int cyc;
        start_op(op, a, b);
        chk({name, "_busy"}, 64'(bus.busy), 64'd1);
        chk({name, "_dbz_clr"}, 64'(bus.div_by_zero), 64'd0);
        wait_done(name, 0, cyc);
        chk({name, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({name, "_lo"}, 64'(bus.lo), 64'(elo));
        chk({name, "_dbz"}, 64'(bus.div_by_zero), 64'(edbz));
        chk({name, "_busy_low"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int cyc;
        bus.start = 1'b0; bus.op = OP_MULT; bus.data1 = '0; bus.data2 = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi",   64'(bus.hi), 64'd0);
        chk("rst_lo",   64'(bus.lo), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", 64'(bus.done), 64'd0);

        run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("divu_b2b", OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0);
        run_op("div_neg",  OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div_ovf",  OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("div_pn",   OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op("mult_nn",  OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("divu_z",   OP_DIVU, 32'd5, 32'd0, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
        repeat (2) @(posedge clk); #1;
        chk("dbz_hold", 64'(bus.div_by_zero), 64'd1);
        run_op("div_z",    OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_clr", OP_MULTU, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 1'b0);

        // Mid-operation start and MTHI must both be ignored.
        start_op(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.op = OP_DIVU; bus.data1 = 32'd9; bus.data2 = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        wait_done("ignore", 10, cyc);
        chk("ignore_hi", 64'(bus.hi), 64'h1);
        chk("ignore_lo", 64'(bus.lo), 64'h0);
        @(negedge clk);
        bus.hi_we = 1'b1; bus.wdata = 32'h1234;
        @(posedge clk); #1;
        bus.hi_we = 1'b0;
        chk("mthi_hi", 64'(bus.hi), 64'h1234);
        chk("mthi_lo", 64'(bus.lo), 64'h0);

        // Reset in the middle of a multiply.
        start_op(OP_MULTU, 32'd6, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hi",   64'(bus.hi), 64'd0);
        chk("abort_lo",   64'(bus.lo), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_no_done", 64'(bus.done), 64'd0);
        run_op("after_rst", OP_MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
